// File: rtl/generic_bus_ram_responder.sv
// Generic-bus RAM responder: byte-enabled word RAM, programmable wait states,
// address-range error. Optional RAM_RESP_RANDOM_STALL_EN adds LFSR stalls.
module generic_bus_ram_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        error
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [4:0]    cnt;
    logic [4:0]    load;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          rd_q;
    logic          wr_q;
    logic          err_q;

    logic          req;
    logic [31:0]   off;
    logic          range_err;
    logic          req_err;

    logic [31:0]   mem [DEPTH];

    assign req = ren | wen;
    assign off = addr - BASE_ADDR;

    // Base is DEPTH*4 aligned, so in-range means no offset bits above the index.
    assign range_err = (addr < BASE_ADDR) || (off[31:AW+2] != '0);
    assign req_err   = range_err || (ren && wen)
                     || (wen && byte_en == 4'b0000);

`ifdef RAM_RESP_RANDOM_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign load = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign load = 5'(LATENCY);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= off[AW+1:2];
                        wdata_q <= wdata;
                        be_q    <= byte_en;
                        rd_q    <= ren;
                        wr_q    <= wen;
                        err_q   <= req_err;
                        cnt     <= load;
                        state   <= (load != 5'd0) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 5'd1;
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt == 5'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Commit happens on the edge leaving DONE; a reset on that edge cancels it.
    always_ff @(posedge CLK) begin
        if (!RST && state == DONE && wr_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign busy  = (state != DONE);
    assign error = (state == DONE) && err_q;
    assign rdata = (state == DONE && rd_q && !err_q) ? mem[idx_q] : 32'h0;

endmodule
